// File: rtl/ahb_copy_master_pkg.sv
// Shared AHB-Lite encodings and the copy-engine state type.
// The AHB constants are the same values the slave-side blocks use.
package ahb_copy_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // RA/WA are address phases, RD/WD the matching data phases.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RA   = 3'd1,
    ST_RD   = 3'd2,
    ST_WA   = 3'd3,
    ST_WD   = 3'd4,
    ST_FIN  = 3'd5,
    ST_ERR  = 3'd6
  } copy_state_t;

  // A byte address is usable for a word transfer only if its low two bits are clear.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ahb_copy_master.sv
// AHB-Lite initiator that copies a block of 32-bit words from src to dst,
// one SINGLE read followed by one SINGLE write per word, never overlapping
// an address phase with a data phase.
module ahb_copy_master
  import ahb_copy_master_pkg::*;
#(
  parameter int         LEN_W     = 16,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  input  logic [31:0]      HRDATA
);

  copy_state_t      state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      buf_q, buf_d;

  logic [31:0]      haddr_q, haddr_d;
  logic [1:0]       htrans_q, htrans_d;
  logic             hwrite_q, hwrite_d;
  logic [31:0]      hwdata_q, hwdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  // Next-state, datapath and registered-output decode; outputs are derived from the state being entered.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    buf_d    = buf_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          src_d = cmd_src;
          dst_d = cmd_dst;
          len_d = cmd_len;
          if (!is_word_aligned(cmd_src) || !is_word_aligned(cmd_dst)) begin
            state_d = ST_ERR;
          end else if (cmd_len == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RA;
          end
        end
      end
      ST_RA: begin
        if (HREADY) state_d = ST_RD;
      end
      ST_RD: begin
        if (HREADY) begin
          if (HRESP == HRESP_ERROR) begin
            state_d = ST_ERR;
          end else begin
            buf_d   = HRDATA;
            state_d = ST_WA;
          end
        end
      end
      ST_WA: begin
        if (HREADY) state_d = ST_WD;
      end
      ST_WD: begin
        if (HREADY) begin
          if (HRESP == HRESP_ERROR) begin
            state_d = ST_ERR;
          end else begin
            src_d   = src_q + 32'd4;
            dst_d   = dst_q + 32'd4;
            len_d   = len_q - LEN_W'(1);
            state_d = (len_q == LEN_W'(1)) ? ST_FIN : ST_RA;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    htrans_d = ((state_d == ST_RA) || (state_d == ST_WA)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    hwrite_d = (state_d == ST_WA);

    // Address only moves when a new address phase starts, so it stays put through wait states.
    haddr_d = haddr_q;
    if (state_d == ST_RA) begin
      haddr_d = src_d;
    end else if (state_d == ST_WA) begin
      haddr_d = dst_d;
    end

    // Write data is loaded on entry to the write data phase and then held until HREADY.
    hwdata_d = hwdata_q;
    if (state_d == ST_WD) begin
      hwdata_d = buf_d;
    end

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FIN);
    err_d   = (state_d == ST_ERR);
    ready_d = (state_d == ST_IDLE);
  end

  // State, datapath and output registers; reset drives the bus idle immediately.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      buf_q    <= '0;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      buf_q    <= buf_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cmd_ready = ready_q;

endmodule
